// File: rtl/lcd_power_seq.sv
// LCD panel power sequencer: supply -> timing controller -> pixel data -> backlight ramp,
// and the reverse on power-down. Counts frames from vsync and generates the backlight PWM.
module lcd_power_seq #(
    parameter int T_PWR_CYC     = 33000,
    parameter int N_FRAMES      = 2,
    parameter int PWM_BITS      = 8,
    parameter int RAMP_STEP_CYC = 1024
) (
    input  logic                clk_in,
    input  logic                sys_rst,
    input  logic                pwr_on_req,
    input  logic                vsync_in,
    input  logic [PWM_BITS-1:0] bl_target,
    output logic                lcd_pwr_en,
    output logic                timing_en,
    output logic                data_en,
    output logic                lcd_bl,
    output logic [PWM_BITS-1:0] bl_level,
    output logic                ready,
    output logic                busy
);

    localparam int DLY_W = $clog2(T_PWR_CYC + 1);
    localparam int FRM_W = $clog2(N_FRAMES + 1);
    localparam int STP_W = $clog2(RAMP_STEP_CYC + 1);

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(T_PWR_CYC - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(N_FRAMES - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(RAMP_STEP_CYC - 1);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWR_UP  = 3'd1,
        ST_SYNC_UP = 3'd2,
        ST_RAMP_UP = 3'd3,
        ST_ON      = 3'd4,
        ST_RAMP_DN = 3'd5,
        ST_SYNC_DN = 3'd6,
        ST_PWR_DN  = 3'd7
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [DLY_W-1:0]    dly_r;
    logic [DLY_W-1:0]    dly_nx_s;
    logic [FRM_W-1:0]    frm_r;
    logic [FRM_W-1:0]    frm_nx_s;
    logic [STP_W-1:0]    stp_r;
    logic [STP_W-1:0]    stp_nx_s;
    logic [PWM_BITS-1:0] lvl_r;
    logic [PWM_BITS-1:0] lvl_nx_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                vs_d_r;
    logic                tick_s;
    logic                step_s;

    logic                pwr_en_r;
    logic                tim_en_r;
    logic                dat_en_r;
    logic                rdy_r;
    logic                busy_r;
    logic                bl_r;
    logic                pwr_en_nx_s;
    logic                tim_en_nx_s;
    logic                dat_en_nx_s;
    logic                rdy_nx_s;
    logic                busy_nx_s;

    // Frame boundary: falling edge of active-low vsync, only while the controller runs
    assign tick_s = vs_d_r & ~vsync_in & tim_en_r;
    assign step_s = (stp_r == STP_LAST);

    // Next-state, counter and backlight-level logic; counters default to zero so every
    // state change restarts them
    always_comb begin
        state_nx_s = state_r;
        dly_nx_s   = '0;
        frm_nx_s   = '0;
        stp_nx_s   = '0;
        lvl_nx_s   = lvl_r;
        case (state_r)
            ST_OFF: begin
                if (pwr_on_req) begin
                    state_nx_s = ST_PWR_UP;
                end else begin
                    state_nx_s = ST_OFF;
                end
            end
            ST_PWR_UP: begin
                if (!pwr_on_req) begin
                    state_nx_s = ST_OFF;
                end else if (dly_r == DLY_LAST) begin
                    state_nx_s = ST_SYNC_UP;
                end else begin
                    dly_nx_s = dly_r + 1'b1;
                end
            end
            ST_SYNC_UP: begin
                if (!pwr_on_req) begin
                    state_nx_s = ST_SYNC_DN;
                end else if (tick_s && (frm_r == FRM_LAST)) begin
                    state_nx_s = ST_RAMP_UP;
                end else if (tick_s) begin
                    frm_nx_s = frm_r + 1'b1;
                end else begin
                    frm_nx_s = frm_r;
                end
            end
            ST_RAMP_UP: begin
                // Level above target (re-entry from ramp-down) is handed to ON to track down
                if (!pwr_on_req) begin
                    state_nx_s = ST_RAMP_DN;
                end else if (lvl_r >= bl_target) begin
                    state_nx_s = ST_ON;
                end else if (step_s) begin
                    lvl_nx_s = lvl_r + 1'b1;
                end else begin
                    stp_nx_s = stp_r + 1'b1;
                end
            end
            ST_ON: begin
                if (!pwr_on_req) begin
                    state_nx_s = ST_RAMP_DN;
                end else if (step_s) begin
                    if (lvl_r < bl_target) begin
                        lvl_nx_s = lvl_r + 1'b1;
                    end else if (lvl_r > bl_target) begin
                        lvl_nx_s = lvl_r - 1'b1;
                    end else begin
                        lvl_nx_s = lvl_r;
                    end
                end else begin
                    stp_nx_s = stp_r + 1'b1;
                end
            end
            ST_RAMP_DN: begin
                if (pwr_on_req) begin
                    state_nx_s = ST_RAMP_UP;
                end else if (lvl_r == '0) begin
                    state_nx_s = ST_SYNC_DN;
                end else if (step_s) begin
                    lvl_nx_s = lvl_r - 1'b1;
                end else begin
                    stp_nx_s = stp_r + 1'b1;
                end
            end
            ST_SYNC_DN: begin
                if (tick_s && (frm_r == FRM_LAST)) begin
                    state_nx_s = ST_PWR_DN;
                end else if (tick_s) begin
                    frm_nx_s = frm_r + 1'b1;
                end else begin
                    frm_nx_s = frm_r;
                end
            end
            ST_PWR_DN: begin
                if (dly_r == DLY_LAST) begin
                    state_nx_s = ST_OFF;
                end else begin
                    dly_nx_s = dly_r + 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_OFF;
                lvl_nx_s   = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs change on the transition edge
    always_comb begin
        pwr_en_nx_s = 1'b0;
        tim_en_nx_s = 1'b0;
        dat_en_nx_s = 1'b0;
        rdy_nx_s    = 1'b0;
        busy_nx_s   = 1'b0;
        case (state_nx_s)
            ST_OFF: begin
                busy_nx_s = 1'b0;
            end
            ST_PWR_UP, ST_PWR_DN: begin
                pwr_en_nx_s = 1'b1;
                busy_nx_s   = 1'b1;
            end
            ST_SYNC_UP, ST_SYNC_DN: begin
                pwr_en_nx_s = 1'b1;
                tim_en_nx_s = 1'b1;
                busy_nx_s   = 1'b1;
            end
            ST_RAMP_UP, ST_RAMP_DN: begin
                pwr_en_nx_s = 1'b1;
                tim_en_nx_s = 1'b1;
                dat_en_nx_s = 1'b1;
                busy_nx_s   = 1'b1;
            end
            ST_ON: begin
                pwr_en_nx_s = 1'b1;
                tim_en_nx_s = 1'b1;
                dat_en_nx_s = 1'b1;
                rdy_nx_s    = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters and registered control outputs
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state_r  <= ST_OFF;
            dly_r    <= '0;
            frm_r    <= '0;
            stp_r    <= '0;
            lvl_r    <= '0;
            vs_d_r   <= 1'b1;
            pwr_en_r <= 1'b0;
            tim_en_r <= 1'b0;
            dat_en_r <= 1'b0;
            rdy_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            dly_r    <= dly_nx_s;
            frm_r    <= frm_nx_s;
            stp_r    <= stp_nx_s;
            lvl_r    <= lvl_nx_s;
            vs_d_r   <= vsync_in;
            pwr_en_r <= pwr_en_nx_s;
            tim_en_r <= tim_en_nx_s;
            dat_en_r <= dat_en_nx_s;
            rdy_r    <= rdy_nx_s;
            busy_r   <= busy_nx_s;
        end
    end

    // Backlight PWM: counter frozen at zero while pixel data is gated
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            pwm_cnt_r <= '0;
            bl_r      <= 1'b0;
        end else if (dat_en_r) begin
            pwm_cnt_r <= pwm_cnt_r + 1'b1;
            bl_r      <= (pwm_cnt_r < lvl_r);
        end else begin
            pwm_cnt_r <= '0;
            bl_r      <= 1'b0;
        end
    end

    assign lcd_pwr_en = pwr_en_r;
    assign timing_en  = tim_en_r;
    assign data_en    = dat_en_r;
    assign ready      = rdy_r;
    assign busy       = busy_r;
    assign bl_level   = lvl_r;
    assign lcd_bl     = bl_r;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Scoreboard bench for lcd_power_seq: expected output-change events are queued when stimulus
// is driven and matched (value and cycle) as the DUT outputs change.
module tb_lcd_power_seq;

    logic       clk_in = 1'b0;
    logic       sys_rst;
    logic       pwr_on_req;
    logic       vsync_in;
    logic [7:0] bl_target;
    logic       lcd_pwr_en;
    logic       timing_en;
    logic       data_en;
    logic       lcd_bl;
    logic [7:0] bl_level;
    logic       ready;
    logic       busy;

    typedef struct {
        int          at;
        logic [12:0] v;
    } evt_t;

    evt_t        sb_q[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic [12:0] prev_v;

    lcd_power_seq #(
        .T_PWR_CYC    (10),
        .N_FRAMES     (2),
        .PWM_BITS     (8),
        .RAMP_STEP_CYC(4)
    ) dut (
        .clk_in    (clk_in),
        .sys_rst   (sys_rst),
        .pwr_on_req(pwr_on_req),
        .vsync_in  (vsync_in),
        .bl_target (bl_target),
        .lcd_pwr_en(lcd_pwr_en),
        .timing_en (timing_en),
        .data_en   (data_en),
        .lcd_bl    (lcd_bl),
        .bl_level  (bl_level),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [12:0] mk(input logic p, input logic t, input logic d,
                                       input logic r, input logic b, input int l);
        return {p, t, d, r, b, 8'(l)};
    endfunction

    task automatic push(input int at, input logic [12:0] v);
        evt_t e;
        e.at = at;
        e.v  = v;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic vs_fall(output int f);
        f        = cyc;
        vsync_in = 1'b0;
    endtask

    task automatic vs_hi();
        step(5);
        vsync_in = 1'b1;
    endtask

    // Monitor: every output change must match the next queued event; invariants every cycle
    always @(negedge clk_in) begin
        logic [12:0] cur;
        evt_t        e;
        if (mon_en) begin
            cur = {lcd_pwr_en, timing_en, data_en, ready, busy, bl_level};
            check_val("invariants", 32'((!data_en || timing_en) && (!timing_en || lcd_pwr_en)
                                        && ((bl_level == 8'd0) || data_en)), 32'd1);
            if (cur !== prev_v) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_change", 32'(cur), 32'(prev_v));
                end else begin
                    e = sb_q.pop_front();
                    check_val("evt_value", 32'(cur), 32'(e.v));
                    check_val("evt_cycle", 32'(cyc), 32'(e.at));
                end
                prev_v = cur;
            end
        end
    end

    // Power up from OFF; drop_lvl >= 0 drops the request during RAMP_UP at that level
    task automatic power_up(input int target, input int drop_lvl, output int on_cyc);
        int c0, f, d;
        pwr_on_req = 1'b1;
        bl_target  = 8'(target);
        c0         = cyc;
        on_cyc     = -1;
        push(c0 + 1, mk(1, 0, 0, 0, 1, 0));
        push(c0 + 11, mk(1, 1, 0, 0, 1, 0));
        step(15);
        vs_fall(f);
        vs_hi();
        step(45);
        vs_fall(f);
        push(f + 1, mk(1, 1, 1, 0, 1, 0));
        if (drop_lvl < 0) begin
            for (int k = 1; k <= target; k++) push(f + 1 + 4 * k, mk(1, 1, 1, 0, 1, k));
            push(f + 2 + 4 * target, mk(1, 1, 1, 1, 0, target));
            vs_hi();
            wait_until(f + 3 + 4 * target);
            on_cyc = f + 2 + 4 * target;
        end else begin
            for (int k = 1; k <= drop_lvl; k++) push(f + 1 + 4 * k, mk(1, 1, 1, 0, 1, k));
            vs_hi();
            wait_until(f + 1 + 4 * drop_lvl);
            pwr_on_req = 1'b0;
            d = cyc;
            for (int k = drop_lvl - 1; k >= 0; k--)
                push(d + 1 + 4 * (drop_lvl - k), mk(1, 1, 1, 0, 1, k));
            push(d + 2 + 4 * drop_lvl, mk(1, 1, 0, 0, 1, 0));
            wait_until(d + 3 + 4 * drop_lvl);
        end
    endtask

    // Drop the request from ON at backlight level lvl; returns once data is gated
    task automatic power_down(input int lvl);
        int d;
        pwr_on_req = 1'b0;
        d = cyc;
        push(d + 1, mk(1, 1, 1, 0, 1, lvl));
        for (int k = lvl - 1; k >= 0; k--) push(d + 1 + 4 * (lvl - k), mk(1, 1, 1, 0, 1, k));
        push(d + 2 + 4 * lvl, mk(1, 1, 0, 0, 1, 0));
        wait_until(d + 3 + 4 * lvl);
    endtask

    // Two frames in SYNC_DN then the supply delay; reup re-requests power meanwhile
    task automatic shutdown_tail(input logic reup);
        int f;
        if (reup) pwr_on_req = 1'b1;
        step(5);
        vs_fall(f);
        vs_hi();
        step(45);
        vs_fall(f);
        push(f + 1, mk(1, 0, 0, 0, 1, 0));
        push(f + 11, mk(0, 0, 0, 0, 0, 0));
        if (reup) begin
            push(f + 12, mk(1, 0, 0, 0, 1, 0));
            push(f + 22, mk(1, 1, 0, 0, 1, 0));
        end
        vs_hi();
        step(45);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int on_c;
        int c;
        int r;
        int hi_cnt;

        sys_rst    = 1'b1;
        pwr_on_req = 1'b0;
        vsync_in   = 1'b1;
        bl_target  = 8'd0;
        step(3);
        check_val("rst_pwr_en", 32'(lcd_pwr_en), 32'd0);
        check_val("rst_timing_en", 32'(timing_en), 32'd0);
        check_val("rst_data_en", 32'(data_en), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_bl_level", 32'(bl_level), 32'd0);
        check_val("rst_lcd_bl", 32'(lcd_bl), 32'd0);
        sys_rst = 1'b0;
        prev_v  = 13'd0;
        mon_en  = 1'b1;
        step(2);

        // Full power-up to level 3, then full power-down
        power_up(3, -1, on_c);
        check_val("on_ready", 32'(ready), 32'd1);
        step(10);
        power_down(3);
        shutdown_tail(1'b0);

        // Tracking in ON and PWM duty at level 2
        power_up(3, -1, on_c);
        wait_until(on_c + 7);
        bl_target = 8'd1;
        push(on_c + 8, mk(1, 1, 1, 1, 0, 2));
        push(on_c + 12, mk(1, 1, 1, 1, 0, 1));
        wait_until(on_c + 13);
        bl_target = 8'd2;
        push(on_c + 16, mk(1, 1, 1, 1, 0, 2));
        wait_until(on_c + 20);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            hi_cnt = hi_cnt + int'(lcd_bl);
        end
        check_val("pwm_high_of_256", 32'(hi_cnt), 32'd2);
        check_val("track_ready", 32'(ready), 32'd1);
        power_down(2);
        shutdown_tail(1'b0);

        // Abort during PWR_UP
        c = cyc;
        pwr_on_req = 1'b1;
        bl_target  = 8'd3;
        push(c + 1, mk(1, 0, 0, 0, 1, 0));
        wait_until(c + 5);
        pwr_on_req = 1'b0;
        push(c + 6, mk(0, 0, 0, 0, 0, 0));
        step(30);

        // Abort during RAMP_UP at level 2, re-request during SYNC_DN
        power_up(3, 2, on_c);
        shutdown_tail(1'b1);
        // Now in SYNC_UP with no vsync activity: must hold there
        step(200);
        check_val("stall_data_en", 32'(data_en), 32'd0);
        check_val("stall_timing_en", 32'(timing_en), 32'd1);
        check_val("stall_busy", 32'(busy), 32'd1);
        pwr_on_req = 1'b0;
        step(1);
        shutdown_tail(1'b0);

        // Synchronous reset while ON
        power_up(3, -1, on_c);
        step(5);
        r = cyc;
        sys_rst    = 1'b1;
        pwr_on_req = 1'b0;
        push(r + 1, mk(0, 0, 0, 0, 0, 0));
        step(2);
        check_val("srst_lcd_bl", 32'(lcd_bl), 32'd0);
        sys_rst = 1'b0;
        step(10);

        // Zero backlight target
        power_up(0, -1, on_c);
        step(10);
        check_val("zero_bl_level", 32'(bl_level), 32'd0);
        power_down(0);
        shutdown_tail(1'b0);

        step(5);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
